data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
Two-master, one-slave arbiter for the 32-bit data bus (addr/dataIn/dataOut/read/write/ready/memType). It shares one memory slave between instruction fetch (m0) and load/store (m1). Each transaction is granted atomically, from request until slave ready. A watchdog aborts any transaction the slave never completes. It sits between the CPU's two bus master ports and the memory/peripheral slave port.

Parameters:
TIMEOUT, 255, max BUSY cycles without s_ready before abort; 0 disables watchdog.
RR_ENABLE, 1, 1 = round-robin between masters; 0 = fixed priority, m1 wins.

Ports:
clk  in  1  system clock; forwarded unchanged on s_clk
rst_n  in  1  asynchronous active-low reset
m0_addr / m1_addr  in  32  master address
m0_dataOut / m1_dataOut  in  32  master write data
m0_read / m1_read  in  1  read request
m0_write / m1_write  in  1  write request
m0_memType / m1_memType  in  3  MemType_t (BYTE=0, WORD=1)
m0_dataIn / m1_dataIn  out  32  read data, broadcast from s_dataIn
m0_ready / m1_ready  out  1  transaction complete, granted master only
m0_err / m1_err  out  1  one-cycle timeout abort flag, coincident with ready
s_addr, s_dataOut  out  32  forwarded from granted master
s_read, s_write  out  1  forwarded strobes
s_memType  out  3  forwarded type
s_clk  out  1  = clk
s_dataIn  in  32  slave read data
s_ready  in  1  slave completion
grant  out  2  one-hot owner (bit0 = m0, bit1 = m1); 0 when idle
busy  out  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0): state IDLE, grant=0, last=m1 (so m0 wins the first RR tie), timeout counter=0.
  - s_read/s_write/m*_ready/m*_err = 0 immediately.
  - s_addr = 0, s_dataOut = 0, s_memType = BYTE.
- A request is (read | write) on a master. The arbiter forwards read+write together unmodified; legality is the master's problem.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Sample requests on the rising edge.
  - One requester: it wins.
  - Both requesting: RR_ENABLE=1 picks the master not in `last`; RR_ENABLE=0 picks m1.
  - Next state BUSY, grant registered, counter cleared.
  - Latency: a request at edge N appears on the slave port during cycle N+1.
- BUSY:
  - s_* = mux(granted master), combinational from the grant register.
  - Granted m_ready = s_ready; the other master's ready = 0.
  - m_dataIn of both masters = s_dataIn at all times.
  - s_ready=1 at an edge: transaction done, last := grant, go RELEASE.
  - Granted master drops both strobes before s_ready (abort): go RELEASE, no ready returned.
  - Counter increments each BUSY cycle. If TIMEOUT≠0 and counter == TIMEOUT-1 with s_ready=0:
    - Drive granted m_ready=1 and m_err=1 for that cycle, forced combinationally.
    - m_dataIn is still s_dataIn; its value is undefined for the master.
    - Go RELEASE.
  - s_ready and timeout in the same cycle: s_ready wins, err=0.
- RELEASE: one bubble cycle.
  - grant=0; slave strobes = 0, s_addr/s_dataOut = 0, s_memType = BYTE.
  - Masters must drop or replace their strobes during this cycle.
  - Next state is IDLE.
  - Guarantees no duplicate grant from a stale request. Minimum cost is 3 cycles per transaction with a 1-cycle-ready slave.
- Non-granted master: its request is held pending with no side effects; m_ready=0, m_err=0.
- s_ready while IDLE or RELEASE: ignored.
- Mid-transaction reset: immediate return to the reset values; no ready is issued.

Decomposition:
- Shared package DataBusArbPkg:
  - ArbState_t enum {IDLE, BUSY, RELEASE}.
  - Grant_t one-hot constants GRANT_NONE=2'b00, GRANT_M0=2'b01, GRANT_M1=2'b10.
- Reuse the existing MemType package for MemType_t.
- One sub-module, arb_rr_pick: combinational 2-way picker (req[1:0], last, rr_enable -> one-hot pick).

Test Plan:
- Single read: m0_read=1, m0_addr=32'h100, memType=WORD, slave ready 2 cycles after the strobe, s_dataIn=32'hCAFEF00D.
  -> s_read rises 1 cycle after the request; m0_ready=1 with m0_dataIn=CAFEF00D; grant 01->00 in RELEASE.
- Contention RR: m0 and m1 both request from reset.
  -> m0 granted first, then m1, then m0 again if both keep requesting. Alternation over 6 transactions.
- Fixed priority: RR_ENABLE=0, both request continuously.
  -> m1 granted every transaction; m0 starves; m0_ready never asserts.
- Timeout: TIMEOUT=8, slave never asserts ready on m1_write.
  -> m1_ready=1 and m1_err=1 exactly 8 cycles after BUSY entry, then RELEASE; s_write drops the next cycle.
- Simultaneous ready and timeout: s_ready in the final count cycle -> ready=1, err=0.
- Reset mid-BUSY: rst_n low while s_write=1 -> s_write=0, grant=0, busy=0 asynchronously. After release, the first contended grant goes to m0.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types for the two-master data bus arbiter: memory access type,
// arbiter FSM states and one-hot grant encodings.
package data_bus_arbiter_pkg;

    // Memory access width carried alongside every bus transaction.
    typedef enum logic [2:0] {
        BYTE = 3'd0,
        WORD = 3'd1
    } MemType_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } ArbState_t;

    // One-hot bus ownership: bit0 = m0, bit1 = m1.
    typedef logic [1:0] Grant_t;

    localparam Grant_t GRANT_NONE = 2'b00;
    localparam Grant_t GRANT_M0   = 2'b01;
    localparam Grant_t GRANT_M1   = 2'b10;

    // Width of a counter that must reach timeout-1; at least one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_pick.sv
// Combinational two-way picker: chooses the bus owner from the current
// request pair, using round-robin on the previous owner or fixed m1 priority.
module arb_rr_pick
    import data_bus_arbiter_pkg::*;
(
    input  logic [1:0] req,        // bit0 = m0 request, bit1 = m1 request
    input  logic       last,       // previous completed owner: 0 = m0, 1 = m1
    input  logic       rr_enable,  // 1 = round-robin, 0 = m1 always wins ties
    output Grant_t     pick
);

    // Select the winner; on a tie round-robin favours the master not served last.
    always_comb begin
        pick = GRANT_NONE;
        unique case (req)
            2'b01:   pick = GRANT_M0;
            2'b10:   pick = GRANT_M1;
            2'b11:   pick = (rr_enable && last) ? GRANT_M0 : GRANT_M1;
            default: pick = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master, one-slave data bus arbiter. Each transaction owns the slave
// from grant until s_ready, followed by a one-cycle release bubble. A
// watchdog aborts a transaction the slave never completes.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT   = 255,   // BUSY cycles without s_ready before abort; 0 disables
    parameter bit RR_ENABLE = 1'b1   // 1 = round-robin, 0 = fixed priority (m1 wins)
) (
    input  logic        clk,
    input  logic        rst_n,

    // Master 0 (instruction fetch)
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [2:0]  m0_memType,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    output logic        m0_err,

    // Master 1 (load/store)
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [2:0]  m1_memType,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic        m1_err,

    // Slave port
    output logic [31:0] s_addr,
    output logic [31:0] s_dataOut,
    output logic        s_read,
    output logic        s_write,
    output logic [2:0]  s_memType,
    output logic        s_clk,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,

    // Status
    output logic [1:0]  grant,
    output logic        busy
);

    localparam int  CW    = cnt_width(TIMEOUT);
    localparam bit  WD_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] CNT_LAST = WD_EN ? CW'(TIMEOUT - 1) : '0;

    ArbState_t      state_q, state_nxt;
    Grant_t         grant_q, grant_nxt;
    logic           last_q, last_nxt;     // 0 = m0 completed last, 1 = m1
    logic [CW-1:0]  cnt_q, cnt_nxt;

    logic [1:0]     req;
    Grant_t         pick;
    logic           gnt_req;              // granted master still strobing
    logic           tmo_hit;              // watchdog expires this cycle
    logic           done_pulse;           // ready returned to the owner
    logic           err_pulse;            // ready is a timeout abort

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign gnt_req = grant_q[1] ? req[1] : req[0];
    assign tmo_hit = WD_EN && (state_q == BUSY) && (cnt_q == CNT_LAST);

    // Read data is broadcast; only the owner's ready qualifies it.
    assign m0_dataIn = s_dataIn;
    assign m1_dataIn = s_dataIn;
    assign s_clk     = clk;
    assign grant     = grant_q;
    assign busy      = (state_q == BUSY);

    arb_rr_pick u_pick (
        .req       (req),
        .last      (last_q),
        .rr_enable (RR_ENABLE),
        .pick      (pick)
    );

    // State, owner, round-robin history and watchdog count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, so the order of these lines is irrelevant.
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            last_q  <= last_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic plus slave forwarding and master handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; a branch that
        // skipped an assignment would otherwise infer a latch.
        state_nxt  = state_q;
        grant_nxt  = grant_q;
        last_nxt   = last_q;
        cnt_nxt    = cnt_q;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        s_addr     = '0;
        s_dataOut  = '0;
        s_read     = 1'b0;
        s_write    = 1'b0;
        s_memType  = BYTE;

        unique case (state_q)
            IDLE: begin
                if (pick != GRANT_NONE) begin
                    state_nxt = BUSY;
                    grant_nxt = pick;
                    cnt_nxt   = '0;
                end
            end

            BUSY: begin
                if (grant_q[1]) begin
                    s_addr    = m1_addr;
                    s_dataOut = m1_dataOut;
                    s_read    = m1_read;
                    s_write   = m1_write;
                    s_memType = m1_memType;
                end else begin
                    s_addr    = m0_addr;
                    s_dataOut = m0_dataOut;
                    s_read    = m0_read;
                    s_write   = m0_write;
                    s_memType = m0_memType;
                end

                if (s_ready) begin
                    // Normal completion beats both abort and timeout.
                    done_pulse = 1'b1;
                    last_nxt   = grant_q[1];
                    grant_nxt  = GRANT_NONE;
                    state_nxt  = RELEASE;
                end else if (!gnt_req) begin
                    // Owner withdrew its strobes: release silently.
                    grant_nxt  = GRANT_NONE;
                    state_nxt  = RELEASE;
                end else if (tmo_hit) begin
                    done_pulse = 1'b1;
                    err_pulse  = 1'b1;
                    grant_nxt  = GRANT_NONE;
                    state_nxt  = RELEASE;
                end else if (cnt_q != '1) begin
                    cnt_nxt    = cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = GRANT_NONE;
            end
        endcase

        m0_ready = done_pulse & grant_q[0];
        m1_ready = done_pulse & grant_q[1];
        m0_err   = err_pulse  & grant_q[0];
        m1_err   = err_pulse  & grant_q[1];
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed scenarios plus random
// transactions checked against a transaction-level reference model.
module tb_data_bus_arbiter;
    import data_bus_arbiter_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Main DUT (round-robin, TIMEOUT=8)
    logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [2:0]  m0_memType, m1_memType;
    logic [31:0] m0_dataIn, m1_dataIn;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] s_addr, s_dataOut, s_dataIn;
    logic        s_read, s_write, s_clk, s_ready, busy;
    logic [2:0]  s_memType;
    logic [1:0]  grant;

    data_bus_arbiter #(.TIMEOUT(TO), .RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_read(m0_read), .m0_write(m0_write),
        .m0_memType(m0_memType), .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_read(m1_read), .m1_write(m1_write),
        .m1_memType(m1_memType), .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
        .s_addr(s_addr), .s_dataOut(s_dataOut), .s_read(s_read), .s_write(s_write),
        .s_memType(s_memType), .s_clk(s_clk), .s_dataIn(s_dataIn), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    // Fixed-priority DUT, both masters reading continuously, slave always ready
    logic [31:0] fp_m0_dataIn, fp_m1_dataIn, fp_s_addr, fp_s_dataOut;
    logic        fp_req, fp_s_ready;
    logic        fp_m0_ready, fp_m0_err, fp_m1_ready, fp_m1_err;
    logic        fp_s_read, fp_s_write, fp_s_clk, fp_busy;
    logic [2:0]  fp_s_memType;
    logic [1:0]  fp_grant;

    data_bus_arbiter #(.TIMEOUT(0), .RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_addr(32'h0000_0010), .m0_dataOut(32'h0), .m0_read(fp_req), .m0_write(1'b0),
        .m0_memType(3'd1), .m0_dataIn(fp_m0_dataIn), .m0_ready(fp_m0_ready), .m0_err(fp_m0_err),
        .m1_addr(32'h0000_0020), .m1_dataOut(32'h0), .m1_read(fp_req), .m1_write(1'b0),
        .m1_memType(3'd1), .m1_dataIn(fp_m1_dataIn), .m1_ready(fp_m1_ready), .m1_err(fp_m1_err),
        .s_addr(fp_s_addr), .s_dataOut(fp_s_dataOut), .s_read(fp_s_read), .s_write(fp_s_write),
        .s_memType(fp_s_memType), .s_clk(fp_s_clk), .s_dataIn(32'h1234_5678), .s_ready(fp_s_ready),
        .grant(fp_grant), .busy(fp_busy)
    );

    // Reference model: per-master request state and the last completed owner
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [2:0]  mt   [2];
    int          last_win;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_masters();
        m0_read = rd[0]; m0_write = wr[0]; m0_addr = addr[0]; m0_dataOut = wdat[0]; m0_memType = mt[0];
        m1_read = rd[1]; m1_write = wr[1]; m1_addr = addr[1]; m1_dataOut = wdat[1]; m1_memType = mt[1];
    endtask

    // Give master m a fresh random request (read, write, or both).
    task automatic new_req(input int m);
        logic [1:0] op;
        op      = 2'($urandom_range(1, 3));
        rd[m]   = op[0];
        wr[m]   = op[1];
        addr[m] = $urandom;
        wdat[m] = $urandom;
        mt[m]   = 3'($urandom_range(0, 1));
    endtask

    function automatic bit has_req(input int m);
        return rd[m] | wr[m];
    endfunction

    // Owner chosen by the arbitration rules from the requests present.
    function automatic int ref_winner(input bit r0, input bit r1, input int last, input bit rr);
        if (r0 && r1) return rr ? ((last == 1) ? 0 : 1) : 1;
        return r1 ? 1 : 0;
    endfunction

    // One transaction starting in an IDLE cycle; the slave answers in BUSY
    // cycle 'lat' (never, if lat exceeds the watchdog limit).
    task automatic run_txn(input int lat, input logic [31:0] rdata, output int win);
        bit hit, tmo, done;
        logic [1:0] exp_rdy, exp_err;
        drive_masters();
        s_ready  = 1'($urandom_range(0, 1));   // ignored while IDLE
        s_dataIn = $urandom;
        @(negedge clk);
        chk("idle_grant", grant, 2'b00);
        chk("idle_ready", {m1_ready, m0_ready}, 2'b00);
        win = ref_winner(has_req(0), has_req(1), last_win, 1'b1);
        @(posedge clk); #1;
        done = 1'b0;
        tmo  = 1'b0;
        for (int c = 1; c <= TO && !done; c++) begin
            hit      = (c == lat);
            tmo      = (c == TO) && !hit;
            s_ready  = hit;
            s_dataIn = hit ? rdata : $urandom;
            @(negedge clk);
            exp_rdy = (hit || tmo) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            exp_err = tmo ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("busy_grant", grant, (win == 1) ? 2'b10 : 2'b01);
            chk("busy_flag", busy, 1'b1);
            chk("s_addr", s_addr, addr[win]);
            chk("s_dataOut", s_dataOut, wdat[win]);
            chk("s_strobes", {s_read, s_write}, {rd[win], wr[win]});
            chk("s_memType", s_memType, mt[win]);
            chk("m_dataIn", {m1_dataIn ^ s_dataIn, m0_dataIn ^ s_dataIn}, 32'h0);
            chk("m_ready", {m1_ready, m0_ready}, exp_rdy);
            chk("m_err", {m1_err, m0_err}, exp_err);
            done = hit || tmo;
            @(posedge clk); #1;
        end
        chk("txn_end", done, 1'b1);
        // RELEASE: owner drops its strobes, the other keeps any pending request
        rd[win] = 1'b0;
        wr[win] = 1'b0;
        drive_masters();
        s_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rel_grant", grant, 2'b00);
        chk("rel_busy", busy, 1'b0);
        chk("rel_strobes", {s_read, s_write}, 2'b00);
        chk("rel_addr", s_addr | s_dataOut, 32'h0);
        chk("rel_memType", s_memType, 3'd0);
        chk("rel_ready", {m1_ready, m0_ready, m1_err, m0_err}, 4'b0);
        if (!tmo) last_win = win;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int win;
        int n1, n0;
        for (int m = 0; m < 2; m++) begin
            rd[m] = 0; wr[m] = 0; addr[m] = 0; wdat[m] = 0; mt[m] = 0;
        end
        drive_masters();
        s_ready = 1'b1; s_dataIn = 32'hDEAD_BEEF;
        fp_req = 1'b1; fp_s_ready = 1'b1;
        last_win = 1;

        // Reset values while rst_n is low
        #12;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {s_read, s_write}, 2'b00);
        chk("rst_addr", s_addr | s_dataOut, 32'h0);
        chk("rst_memType", s_memType, 3'd0);
        chk("rst_ready", {m1_ready, m0_ready, m1_err, m0_err}, 4'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_ready = 1'b0;

        // Fixed priority: m1 wins every 3-cycle transaction, m0 starves
        n1 = 0; n0 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fp_m1_ready) n1++;
            if (fp_m0_ready) n0++;
            chk("fp_no_m0_grant", fp_grant[0], 1'b0);
        end
        chk("fp_m1_count", n1, 10);
        chk("fp_m0_count", n0, 0);
        @(posedge clk); #1;

        // Round-robin contention from reset: m0, m1, m0, ...
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < 2; m++) if (!has_req(m)) new_req(m);
            run_txn($urandom_range(1, 3), $urandom, win);
            chk("rr_order", win, i % 2);
        end

        // Single read of m0 with a 2-cycle slave
        rd[0] = 1; wr[0] = 0; addr[0] = 32'h100; wdat[0] = 0; mt[0] = WORD;
        rd[1] = 0; wr[1] = 0;
        run_txn(2, 32'hCAFE_F00D, win);
        chk("single_win", win, 0);

        // Watchdog abort on a write the slave never answers
        rd[1] = 0; wr[1] = 1; addr[1] = 32'h2000; wdat[1] = 32'h5555_AAAA; mt[1] = BYTE;
        run_txn(1000, 32'h0, win);

        // Ready in the final watchdog cycle: normal completion, no error
        rd[1] = 0; wr[1] = 1; addr[1] = 32'h2004; wdat[1] = 32'h0F0F_0F0F; mt[1] = WORD;
        run_txn(TO, 32'h1111_2222, win);

        // Random traffic, including pending requests and timeouts
        for (int i = 0; i < 40; i++) begin
            for (int m = 0; m < 2; m++) if (!has_req(m) && $urandom_range(0, 1) == 1) new_req(m);
            if (!has_req(0) && !has_req(1)) new_req($urandom_range(0, 1));
            run_txn($urandom_range(1, TO + 3), $urandom, win);
        end

        // Reset in the middle of a write; first contended grant afterwards goes to m0
        rd[1] = 0; wr[1] = 0;
        rd[0] = 1; wr[0] = 0; addr[0] = 32'h40; mt[0] = WORD;
        run_txn(1, 32'h0, win);                    // leaves m0 as last owner
        rd[1] = 0; wr[1] = 1; addr[1] = 32'h3000; wdat[1] = 32'h7777_8888; mt[1] = WORD;
        drive_masters();
        s_ready = 1'b0;
        @(posedge clk); #1;                        // now BUSY for m1
        @(negedge clk);
        chk("pre_rst_write", s_write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_write", s_write, 1'b0);
        chk("mid_rst_grant", grant, 2'b00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", {m1_ready, m1_err}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_win = 1;
        new_req(0);
        run_txn(2, $urandom, win);
        chk("post_rst_win", win, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
